// File: rtl/imem_pkg.sv
// imem_pkg: shared constants, state codes and sizing helpers for the instruction memory
package imem_pkg;

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    localparam int NOP_INSTR = 0;

    function automatic int bytes_per_instr(input int instr_w);
        return instr_w / 8;
    endfunction

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/imem_byte_ram.sv
// imem_byte_ram: DEPTH x 8 byte store with one synchronous write port and a combinational big-endian instruction read
module imem_byte_ram
    import imem_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 256,
    parameter int IW      = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [IW-1:0]      waddr_i,
    input  logic [7:0]         wdata_i,
    input  logic [IW-1:0]      raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    localparam int BYTES = bytes_per_instr(INSTR_W);

    logic [7:0] mem [DEPTH];

    // Single byte write per cycle; contents deliberately have no reset
    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    // Lowest address lands in the most significant byte of the instruction
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < BYTES; i++)
            rdata_o[INSTR_W-1-8*i -: 8] = mem[raddr_i + IW'(i)];
    end

endmodule

// File: rtl/imem_banked_loader.sv
// imem_banked_loader: writable IF-stage instruction memory with post-reset clear sweep, stall-holding registered fetch and fault flags
module imem_banked_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_req,
    input  logic [ADDR_W-1:0]  fetch_addr,
    input  logic               fetch_stall,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic               fault_misalign,
    output logic               fault_range,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [7:0]         prog_data,
    output logic               busy
);

    localparam int BYTES = bytes_per_instr(INSTR_W);
    localparam int IW    = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << clog2(BYTES)) - 1);

    logic [0:0]         state_q, state_d;
    logic [IW-1:0]      clr_ptr_q, clr_ptr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               mis_q, mis_d;
    logic               rng_q, rng_d;

    logic               ready, accept, hold, is_mis, is_rng, prog_ok;
    logic               ram_we;
    logic [IW-1:0]      ram_waddr;
    logic [7:0]         ram_wdata;
    logic [INSTR_W-1:0] rdata;

    assign ready   = state_q == S_READY;
    assign busy    = !ready;
    assign hold    = ready && fetch_stall;
    assign accept  = ready && !fetch_stall && fetch_req;
    assign is_mis  = |(fetch_addr & ALIGN_MASK);
    // One extra bit so addresses near the top of the space cannot wrap into range
    assign is_rng  = ({1'b0, fetch_addr} + (ADDR_W+1)'(BYTES)) > (ADDR_W+1)'(DEPTH);
    assign prog_ok = {1'b0, prog_addr} < (ADDR_W+1)'(DEPTH);

    assign ram_we    = busy || (prog_we && prog_ok);
    assign ram_waddr = busy ? clr_ptr_q : prog_addr[IW-1:0];
    assign ram_wdata = busy ? 8'h00 : prog_data;

    imem_byte_ram #(
        .INSTR_W(INSTR_W),
        .DEPTH  (DEPTH),
        .IW     (IW)
    ) u_ram (
        .clk    (clk),
        .we_i   (ram_we),
        .waddr_i(ram_waddr),
        .wdata_i(ram_wdata),
        .raddr_i(fetch_addr[IW-1:0]),
        .rdata_o(rdata)
    );

    // Next-state: sweep pointer, one-way clear-to-ready transition, fetch result registers
    always_comb begin
        state_d   = (!ready && clr_ptr_q == IW'(DEPTH - 1)) ? S_READY : state_q;
        clr_ptr_d = busy ? clr_ptr_q + IW'(1) : clr_ptr_q;
        valid_d   = hold ? valid_q : accept;
        mis_d     = hold ? mis_q : accept && is_mis;
        rng_d     = hold ? rng_q : accept && is_rng;
        instr_d   = hold ? instr_q : (accept && !is_mis && !is_rng) ? rdata : INSTR_W'(NOP_INSTR);
    end

    // State and fetch outputs, cleared asynchronously by rst low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_CLEAR;
            clr_ptr_q <= '0;
            instr_q   <= INSTR_W'(NOP_INSTR);
            valid_q   <= 1'b0;
            mis_q     <= 1'b0;
            rng_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            mis_q     <= mis_d;
            rng_q     <= rng_d;
        end
    end

    assign instr          = instr_q;
    assign instr_valid    = valid_q;
    assign fault_misalign = mis_q;
    assign fault_range    = rng_q;

endmodule

// File: tb/tb_imem_banked_loader.sv
// tb_imem_banked_loader: vector table, random reference-model and reset/clear sequences for imem_banked_loader
module tb_imem_banked_loader;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;
    localparam int DEPTH   = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic               fetch_req = 1'b0;
    logic [ADDR_W-1:0]  fetch_addr = '0;
    logic               fetch_stall = 1'b0;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid, fault_misalign, fault_range, busy;
    logic               prog_we = 1'b0;
    logic [ADDR_W-1:0]  prog_addr = '0;
    logic [7:0]         prog_data = '0;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem_m [DEPTH];

    typedef struct {
        logic        we;
        logic [15:0] waddr;
        logic [7:0]  wdata;
        logic        req;
        logic [15:0] addr;
        logic        stall;
        logic [15:0] e_instr;
        logic        e_valid;
        logic        e_mis;
        logic        e_rng;
    } vec_t;

    vec_t vecs [23];

    imem_banked_loader #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .fetch_stall   (fetch_stall),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .fault_misalign(fault_misalign),
        .fault_range   (fault_range),
        .prog_we       (prog_we),
        .prog_addr     (prog_addr),
        .prog_data     (prog_data),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [15:0] ei, input logic ev, input logic em, input logic er);
        check({tag, ".instr"}, 32'(instr), 32'(ei));
        check({tag, ".valid"}, 32'(instr_valid), 32'(ev));
        check({tag, ".mis"}, 32'(fault_misalign), 32'(em));
        check({tag, ".rng"}, 32'(fault_range), 32'(er));
    endtask

    task automatic wait_clear(input string tag);
        int cnt;
        cnt = 0;
        fetch_req = 1'b1;
        fetch_addr = '0;
        prog_we = 1'b1;
        prog_addr = 16'h0000;
        prog_data = 8'hEE;
        while (busy && cnt < 200) begin
            step();
            cnt++;
            if (busy) check({tag, ".valid_busy"}, 32'(instr_valid), 32'd0);
        end
        check({tag, ".busy_cycles"}, 32'(cnt), 32'(DEPTH));
        check({tag, ".valid_last_clear"}, 32'(instr_valid), 32'd0);
        prog_we = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
    endtask

    function automatic vec_t mk(input logic we, input logic [15:0] wa, input logic [7:0] wd,
                                input logic req, input logic [15:0] a, input logic st,
                                input logic [15:0] ei, input logic ev, input logic em, input logic er);
        vec_t v;
        v.we = we; v.waddr = wa; v.wdata = wd; v.req = req; v.addr = a; v.stall = st;
        v.e_instr = ei; v.e_valid = ev; v.e_mis = em; v.e_rng = er;
        return v;
    endfunction

    initial begin
        logic [15:0] ei;
        logic        ev, em, er;
        int          a;

        vecs[0]  = mk(1, 16'h0000, 8'h11, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
        vecs[1]  = mk(1, 16'h0001, 8'h20, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
        vecs[2]  = mk(1, 16'h0002, 8'h12, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
        vecs[3]  = mk(1, 16'h0003, 8'hD1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
        vecs[4]  = mk(0, 16'h0000, 8'h00, 1, 16'h0000, 0, 16'h1120, 1, 0, 0);
        vecs[5]  = mk(0, 16'h0000, 8'h00, 1, 16'h0002, 0, 16'h12D1, 1, 0, 0);
        vecs[6]  = mk(0, 16'h0000, 8'h00, 1, 16'h0003, 0, 16'h0000, 1, 1, 0);
        vecs[7]  = mk(0, 16'h0000, 8'h00, 1, 16'h003E, 0, 16'h0000, 1, 0, 0);
        vecs[8]  = mk(0, 16'h0000, 8'h00, 1, 16'h0040, 0, 16'h0000, 1, 0, 1);
        vecs[9]  = mk(0, 16'h0000, 8'h00, 1, 16'hFFFE, 0, 16'h0000, 1, 0, 1);
        vecs[10] = mk(0, 16'h0000, 8'h00, 1, 16'hFFFF, 0, 16'h0000, 1, 1, 1);
        vecs[11] = mk(0, 16'h0000, 8'h00, 0, 16'h0002, 0, 16'h0000, 0, 0, 0);
        vecs[12] = mk(0, 16'h0000, 8'h00, 1, 16'h0000, 0, 16'h1120, 1, 0, 0);
        vecs[13] = mk(0, 16'h0000, 8'h00, 1, 16'h0002, 1, 16'h1120, 1, 0, 0);
        vecs[14] = mk(0, 16'h0000, 8'h00, 1, 16'h0002, 1, 16'h1120, 1, 0, 0);
        vecs[15] = mk(0, 16'h0000, 8'h00, 1, 16'h0002, 1, 16'h1120, 1, 0, 0);
        vecs[16] = mk(0, 16'h0000, 8'h00, 1, 16'h0002, 0, 16'h12D1, 1, 0, 0);
        vecs[17] = mk(1, 16'h0000, 8'hAB, 1, 16'h0000, 0, 16'h1120, 1, 0, 0);
        vecs[18] = mk(0, 16'h0000, 8'h00, 1, 16'h0000, 0, 16'hAB20, 1, 0, 0);
        vecs[19] = mk(1, 16'h0040, 8'h55, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
        vecs[20] = mk(0, 16'h0000, 8'h00, 1, 16'h0000, 0, 16'hAB20, 1, 0, 0);
        vecs[21] = mk(1, 16'h0004, 8'h77, 1, 16'h0000, 1, 16'hAB20, 1, 0, 0);
        vecs[22] = mk(0, 16'h0000, 8'h00, 1, 16'h0004, 0, 16'h7700, 1, 0, 0);

        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check_out("reset", 16'h0000, 0, 0, 0);
        check("reset.busy", 32'(busy), 32'd1);
        step();
        step();
        rst = 1'b1;
        wait_clear("clear");

        fetch_req = 1'b1;
        fetch_addr = 16'h0000;
        step();
        check_out("post_clear_fetch", 16'h0000, 1, 0, 0);

        for (int i = 0; i < 23; i++) begin
            prog_we = vecs[i].we;
            prog_addr = vecs[i].waddr;
            prog_data = vecs[i].wdata;
            fetch_req = vecs[i].req;
            fetch_addr = vecs[i].addr;
            fetch_stall = vecs[i].stall;
            if (vecs[i].we && vecs[i].waddr < DEPTH) mem_m[vecs[i].waddr] = vecs[i].wdata;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_valid, vecs[i].e_mis, vecs[i].e_rng);
        end

        ei = 16'h7700; ev = 1'b1; em = 1'b0; er = 1'b0;
        for (int n = 0; n < 400; n++) begin
            prog_we = ($urandom_range(0, 2) == 0);
            prog_addr = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 80));
            prog_data = 8'($urandom);
            fetch_req = ($urandom_range(0, 3) != 0);
            fetch_addr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 70));
            fetch_stall = ($urandom_range(0, 4) == 0);
            if (!fetch_stall) begin
                a = int'(fetch_addr);
                ev = fetch_req;
                em = fetch_req && (a % 2 != 0);
                er = fetch_req && (a + 2 > DEPTH);
                ei = (fetch_req && !em && !er) ? {mem_m[a], mem_m[a+1]} : 16'h0000;
            end
            if (prog_we && int'(prog_addr) < DEPTH) mem_m[prog_addr] = prog_data;
            step();
            check_out($sformatf("rand%0d", n), ei, ev, em, er);
        end

        prog_we = 1'b0;
        fetch_stall = 1'b0;
        fetch_req = 1'b0;
        step();
        prog_we = 1'b1;
        prog_addr = 16'h0000;
        prog_data = 8'h5A;
        step();
        prog_addr = 16'h0001;
        step();
        prog_we = 1'b0;
        fetch_req = 1'b1;
        fetch_addr = 16'h0000;
        step();
        check_out("pre_reset", 16'h5A5A, 1, 0, 0);
        #2 rst = 1'b0;
        #1;
        check_out("async_reset", 16'h0000, 0, 0, 0);
        check("async_reset.busy", 32'(busy), 32'd1);
        step();
        rst = 1'b1;
        wait_clear("reclear");
        fetch_req = 1'b1;
        fetch_addr = 16'h0000;
        step();
        check_out("reclear_fetch0", 16'h0000, 1, 0, 0);
        fetch_addr = 16'h0002;
        step();
        check_out("reclear_fetch2", 16'h0000, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_banked_loader.md
Name: imem_banked_loader

Overview:
- Parametrised byte-addressed instruction memory for the 5-stage pipeline IF stage.
- Replaces a fixed, hard-coded ROM with a writable store:
  - a byte program-load port;
  - a sequential clear sweep after reset;
  - a registered fetch with stall hold;
  - misalignment and out-of-range fault reporting, consumed by the exception logic.
- Instructions are stored big-endian: lowest address holds the MSB byte.

Parameters:
- ADDR_W, 16: width of fetch and program addresses.
- INSTR_W, 16: instruction width. Must be a multiple of 8. BYTES = INSTR_W/8.
- DEPTH, 256: memory size in bytes. Must be a multiple of BYTES and ≤ 2^ADDR_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- fetch_req  in  1  IF stage requests an instruction at fetch_addr.
- fetch_addr  in  ADDR_W  byte address of the instruction (PC).
- fetch_stall  in  1  pipeline stall: hold all fetch outputs, accept no new request.
- instr  out  INSTR_W  fetched instruction; 0 (NOP) when invalid or faulted.
- instr_valid  out  1  instr/fault outputs correspond to an accepted request.
- fault_misalign  out  1  accepted request had fetch_addr mod BYTES ≠ 0.
- fault_range  out  1  accepted request had fetch_addr + BYTES > DEPTH.
- prog_we  in  1  program-load byte write enable.
- prog_addr  in  ADDR_W  program-load byte address.
- prog_data  in  8  program-load byte.
- busy  out  1  clear sweep in progress; fetch and program ports are ignored.

Behaviour:
- Reset (rst=0, asynchronous):
  - instr=0, instr_valid=0, fault_misalign=0, fault_range=0, busy=1.
  - state=S_CLEAR, clr_ptr=0.
  - Memory array is not asynchronously reset.
- S_CLEAR:
  - Each cycle writes 0 to mem[clr_ptr], then clr_ptr+1.
  - After the write to mem[DEPTH-1], go to S_READY next cycle; busy=0 from that cycle.
  - Clear duration is exactly DEPTH cycles after rst deasserts.
  - fetch_req and prog_we are ignored; instr_valid stays 0.
  - Reset asserted mid-clear restarts the sweep at 0.
- S_READY fetch (1-cycle latency):
  - If fetch_stall=1 at the edge: instr, instr_valid and both fault flags hold their values; no request is accepted.
  - Else if fetch_req=1: the request is accepted. On the next cycle instr_valid=1 and:
    - no fault: instr = {mem[a], mem[a+1], …, mem[a+BYTES-1]}, MSB first;
    - any fault: instr=0 and the matching fault flag(s) =1. Both flags may be set together.
  - Else: instr_valid=0, instr=0, faults=0.
- Fault rules:
  - Misalignment: fetch_addr[log2(BYTES)-1:0] ≠ 0. Never set when BYTES=1.
  - Range check uses ADDR_W+1-bit arithmetic. No wrap-around, no modulo: e.g. 0xFFFE with DEPTH=256 faults.
- Program port:
  - In S_READY, prog_we=1 writes prog_data to mem[prog_addr] if prog_addr < DEPTH.
  - Out-of-range writes are silently dropped.
  - Writes are accepted regardless of fetch_stall.
- Same-cycle write and fetch touching the same byte: the fetch returns the old data (read-before-write); the new data is visible to the next accepted fetch.
- State machine: S_CLEAR → S_READY only. S_READY returns to S_CLEAR only via rst.

Decomposition:
- Package imem_pkg:
  - state enum {S_CLEAR, S_READY};
  - constant NOP_INSTR = 0;
  - function bytes_per_instr(INSTR_W);
  - function clog2 for the alignment mask.
- Sub-module imem_byte_ram:
  - DEPTH×8 array, one synchronous byte write port;
  - combinational BYTES-wide big-endian read;
  - the top level muxes the write port between the clear sweep and prog_*.

Test Plan:
- Clear sweep, DEPTH=64:
  - release rst → busy=1 for exactly 64 cycles, then 0;
  - fetch_req=1 during busy → instr_valid=0;
  - after the sweep, fetch 0x0000 → instr=0x0000, instr_valid=1.
- Load and fetch, INSTR_W=16:
  - write 0x11 @0, 0x20 @1, 0x12 @2, 0xD1 @3;
  - fetch 0x0000 → next cycle instr=0x1120;
  - fetch 0x0002 → instr=0x12D1, faults 0.
- Faults, DEPTH=64:
  - fetch 0x0003 → fault_misalign=1, instr=0, valid=1;
  - fetch 0x003E → valid data;
  - fetch 0x0040 → fault_range=1;
  - fetch 0xFFFE → fault_range=1 (no overflow);
  - fetch 0xFFFF → both flags=1.
- Stall:
  - fetch 0x0000 (instr=0x1120), then fetch_stall=1 for 3 cycles with fetch_addr=0x0002 → instr stays 0x1120, valid=1;
  - release → next cycle instr=0x12D1.
- Write/fetch collision:
  - mem[0..1]=0x1120; same cycle prog_we writes 0xAB @0 and fetch 0x0000 → instr=0x1120;
  - refetch 0x0000 → 0xAB20.
- Reset mid-operation:
  - rst=0 during S_READY with instr_valid=1 → all outputs 0 immediately (asynchronous), busy=1;
  - previously loaded bytes read 0 after the new sweep completes.
